// File: rtl/avalon_mem_pkg.sv
// Shared types and defaults for the Avalon slave memory.
//   state_t      : transfer FSM states (IDLE, STALL, ACK)
//   DEFAULT_WAIT : default extra stall cycles per transfer
//   DEFAULT_DEPTH: default number of 32-bit words
//   idx_width()  : word-index width needed for a given depth
package avalon_mem_pkg;

    localparam int unsigned DEFAULT_WAIT  = 2;
    localparam int unsigned DEFAULT_DEPTH = 256;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/avalon_slave_mem_if.sv
// Avalon-MM bus bundle between a master and the slave memory.
//   master: drives address/read/write/writedata/byteenable, sees waitrequest/readdata
//   slave : the reverse
interface avalon_slave_mem_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_mem_array.sv
// Word storage with byte-lane bus write, asynchronous read and a preload port.
//   clk                  : clock
//   wr_en/wr_idx/wr_data/wr_be : bus write, only enabled lanes updated
//   rd_idx/rd_data       : combinational read port
//   load_en/load_idx/load_data : full-word preload, dropped when out of range
// Contents are never reset.
module avalon_mem_array
    import avalon_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW   = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              load_en,
    input  logic [29:0]       load_idx,
    input  logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              load_ok;

    assign load_ok = load_en && ({2'b00, load_idx} < 32'(DEPTH));
    assign rd_data = mem[rd_idx];

    // Preload is issued after the bus write so it wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (load_ok) begin
            mem[load_idx[AW-1:0]] <= load_data;
        end
    end

endmodule

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave memory with fixed wait states and a preload port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : Avalon slave modport (address/read/write/writedata/byteenable in,
//                waitrequest combinational out, readdata registered out)
//   load_*     : program-image preload, independent of FSM and reset
//   err        : sticky error (out of range, read+write together, aborted request)
module avalon_slave_mem
    import avalon_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT
) (
    input  logic                      clk,
    input  logic                      reset,
    avalon_slave_mem_if.slave         bus,
    input  logic                      load_en,
    input  logic [31:0]               load_addr,
    input  logic [31:0]               load_data,
    output logic                      err
);

    localparam int unsigned AW = idx_width(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_d;
    logic              req;
    logic              in_range;
    logic              rd_load;
    logic              wr_en;
    logic [29:0]       word_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        unused_addr_lsb;

    assign req             = bus.read || bus.write;
    assign word_idx        = bus.address[31:2];
    assign unused_addr_lsb = bus.address[1:0];
    assign in_range        = ({2'b00, word_idx} < 32'(DEPTH_WORDS));
    assign bus.waitrequest = req && (state_q != ACK);

    avalon_mem_array #(
        .DEPTH (DEPTH_WORDS)
    ) u_array (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_idx    (word_idx[AW-1:0]),
        .wr_data   (bus.writedata),
        .wr_be     (bus.byteenable),
        .rd_idx    (word_idx[AW-1:0]),
        .rd_data   (mem_rdata),
        .load_en   (load_en),
        .load_idx  (load_addr[31:2]),
        .load_data (load_data)
    );

    // State, counter, readdata and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err     <= err_d;
            if (rd_load) begin
                bus.readdata <= in_range ? mem_rdata : '0;
            end
        end
    end

    // Next state; readdata is captured on the edge entering ACK so it is
    // valid throughout the ACK cycle, writes commit on the edge leaving ACK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err;
        rd_load = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                        rd_load = bus.read;
                    end else begin
                        state_d = STALL;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            STALL: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    rd_load = bus.read;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                if (req) begin
                    if (!in_range || (bus.read && bus.write)) begin
                        err_d = 1'b1;
                    end
                    wr_en = bus.write && !bus.read && in_range && !reset;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: doc/avalon_slave_mem.md
AVALON_SLAVE_MEM -- requirements
Module: avalon_slave_mem

Interface
REQ-001 Parameter DEPTH_WORDS, 256, number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, 2, extra stall cycles per transfer (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  32  Avalon byte address from master; word index = address[31:2].
REQ-006 read  input  1  Avalon read request.
REQ-007 write  input  1  Avalon write request.
REQ-008 writedata  input  32  Avalon write data.
REQ-009 byteenable  input  4  Avalon byte-lane enables; bit n covers writedata[8n+7:8n].
REQ-010 waitrequest  output  1  Avalon stall to master.
REQ-011 readdata  output  32  Avalon read data.
REQ-012 load_en  input  1  preload strobe for the program image.
REQ-013 load_addr  input  32  preload byte address.
REQ-014 load_data  input  32  preload word.
REQ-015 err  output  1  sticky protocol or range error flag.

Function
REQ-016 FSM states SHALL be IDLE, STALL and ACK.
REQ-017 In IDLE, read|write high SHALL load the stall counter with WAIT_CYCLES and move to STALL, or to ACK when WAIT_CYCLES=0.
REQ-018 In STALL, the counter SHALL decrement each cycle; at zero the FSM SHALL move to ACK.
REQ-019 ACK SHALL last exactly one cycle, then return to IDLE; a request present in the following cycle starts a new transfer.
REQ-020 waitrequest SHALL equal (read|write) AND state!=ACK, combinationally; it is low with no request.
REQ-021 Per transfer, waitrequest SHALL be high for exactly WAIT_CYCLES+1 cycles, then low for one cycle.
REQ-022 readdata SHALL be registered: it holds mem[word index] during the ACK cycle of a read and keeps its value until the next read ACK.
REQ-023 A write SHALL commit on the clock edge ending ACK, updating only enabled byte lanes; byteenable=4'b0000 leaves the word unchanged.
REQ-024 address[1:0] SHALL be ignored; there is no misalignment error.
REQ-025 Word index >= DEPTH_WORDS SHALL complete with normal timing: read returns 32'h0, write is dropped, err is set.
REQ-026 read and write both high SHALL be performed as a read only and SHALL set err.
REQ-027 Request dropped while in STALL SHALL abort to IDLE with no write, no readdata update, and err set.
REQ-028 Address, writedata and byteenable SHALL be sampled in ACK; master stability during STALL is the master's obligation.
REQ-029 load_en high SHALL write load_data to mem[load_addr[31:2]] on that edge, independent of FSM state and reset.
REQ-030 An out-of-range preload SHALL be dropped silently.
REQ-031 On a same-cycle, same-word collision of preload and a bus write commit, the preload SHALL win.

Reset
REQ-032 reset SHALL asynchronously force FSM=IDLE, counter=0, readdata=32'h0 and err=0.
REQ-033 While reset is high, waitrequest SHALL be high whenever read|write is high.
REQ-034 reset SHALL NOT clear memory contents.
REQ-035 reset asserted mid-transfer SHALL abandon the transfer with no write commit.

Structure
REQ-036 Package avalon_mem_pkg SHALL hold the FSM state enum, DEFAULT_WAIT=2 and DEFAULT_DEPTH=256.
REQ-037 Storage with byte-lane write and preload port SHALL be a sub-module, avalon_mem_array.
REQ-038 FSM, counter, range check and err SHALL live in avalon_slave_mem.

Verification
REQ-039 Preload 0x2404FEDC at 0x04, then read 0x04 with WAIT_CYCLES=2 -> waitrequest high 3 cycles, low 1 cycle with readdata=0x2404FEDC.
REQ-040 Write 0xAABBCCDD, byteenable=4'b0101, to 0x10 holding 0x11223344, then read 0x10 -> 0x11BB33DD, err=0.
REQ-041 Read 0x400 with DEPTH_WORDS=256 -> normal timing, readdata=0x0, err=1 sticky until reset.
REQ-042 read and write both high at 0x08 (content 0x12345678) -> readdata=0x12345678, word unchanged, err=1.
REQ-043 Drop write after 1 STALL cycle, and separately assert reset mid-STALL -> word unchanged, FSM back in IDLE, waitrequest low.
REQ-044 Back-to-back reads 0x04, 0x08 with WAIT_CYCLES=0 -> waitrequest pattern 1,0,1,0, correct data each ACK.
